mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Block-copy engine sitting directly upstream of the single-port data memory; owns the memory's address/write/data-in pins.
- When idle, forwards the core's load/store signals to the memory unchanged.
- On Start, copies Length words from SrcAddr to DstAddr through the one shared address pointer, stalling the core until done.

Parameters:
- W, 8, data word width (matches data memory width).
- A, 8, address width; memory depth 2**A.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- SrcAddr  input  A  first source address.
- DstAddr  input  A  first destination address.
- Length  input  A+1  word count, 0..2**A.
- Busy  output  1  high in READ/WRITE; core must stall.
- Done  output  1  one-cycle pulse after the final write (or after a zero-length request).
- CpuMemWrite  input  1  core store enable.
- CpuAddr  input  A  core address.
- CpuWrData  input  W  core store data.
- CpuRdData  output  W  core load data; always equals MemRdData.
- MemWrite  output  1  to memory write enable.
- MemAddr  output  A  to memory address.
- MemWrData  output  W  to memory write data.
- MemRdData  input  W  from memory combinational read data.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, Busy=0, Done=0, internal counters/hold register=0. Mem* outputs pass the Cpu* inputs through.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - MemWrite=CpuMemWrite, MemAddr=CpuAddr, MemWrData=CpuWrData.
  - Start=1 with Length>0: latch src/dst/remaining, go to READ.
  - Start=1 with Length=0: go to DONE with no memory access.
- READ:
  - MemAddr=src, MemWrite=0.
  - Capture MemRdData into hold register at clock edge; go to WRITE.
- WRITE:
  - MemAddr=dst, MemWrData=hold, MemWrite=1.
  - At edge: src+=1, dst+=1 (mod 2**A, wrap 0xFF->0x00), remaining-=1.
  - remaining was 1: go to DONE; otherwise go to READ.
- DONE: Done=1 for exactly one cycle, Busy=0, Mem* pass through from core; go to IDLE.
- Latency: N-word copy takes 2N cycles of Busy after the Start edge; Done follows in the next cycle.
- While Busy: Cpu* inputs are ignored (core store suppressed); Start is ignored.
- Overlap: copy is strictly forward, word by word. Overlap with DstAddr>SrcAddr propagates already-copied data; this is defined behaviour, not an error.
- Length=2**A: copies the entire memory, wrapping addresses.
- Reset mid-copy: abort immediately to IDLE; words already written stay written; no Done pulse.

Optional Feature:
- Macro: MEM_COPY_FILL_EN.
- Defined:
  - Adds inputs Fill (1) and FillValue (W), sampled with Start.
  - Fill=1 skips READ: each WRITE stores FillValue to dst.
  - N-word fill takes N Busy cycles; SrcAddr is ignored.
- Undefined: ports absent; copy-only behaviour.

Decomposition:
- Shared package mem_pkg holds:
  - state enum typedef (IDLE, READ, WRITE, DONE);
  - default widths W=8, A=8.
- No sub-module: FSM, counters and output mux stay in a single module.

Test Plan:
- Preload mem[0x10..0x13]=AA,BB,CC,DD; Start, Src=0x10, Dst=0x80, Len=4 -> mem[0x80..0x83]=AA,BB,CC,DD; Busy high 8 cycles; Done pulses once on cycle 9.
- Start, Len=0 -> Busy never high; Done pulses the next cycle; memory unchanged.
- Src=0xFE, Dst=0x40, Len=4 -> mem[0x40..0x43]=mem[0xFE],mem[0xFF],mem[0x00],mem[0x01].
- Idle: CpuMemWrite=1, CpuAddr=0x22, CpuWrData=0x5A -> mem[0x22]=0x5A. Same store issued while Busy -> mem[0x22] unchanged.
- Second Start during a 4-word copy -> ignored; exactly 4 words copied, one Done.
- Reset asserted after the 2nd WRITE of a 4-word copy -> 2 words copied, IDLE next cycle, Busy=0, no Done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy engine: default widths and FSM state type.
package mem_pkg;

    localparam int unsigned DefW = 8;  // data word width
    localparam int unsigned DefA = 8;  // address width

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy engine owning the data memory's address/write/data-in pins.
// Idle: core load/store passes straight through. On Start, copies Length words
// from SrcAddr to DstAddr (one READ then one WRITE per word), stalling the core.
// Optional build macro MEM_COPY_FILL_EN adds a fill mode (Fill, FillValue) that
// skips READ and writes FillValue to each destination word.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int unsigned W = DefW,
    parameter int unsigned A = DefA
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A:0]   Length,
`ifdef MEM_COPY_FILL_EN
    input  logic         Fill,
    input  logic [W-1:0] FillValue,
`endif
    output logic         Busy,
    output logic         Done,
    input  logic         CpuMemWrite,
    input  logic [A-1:0] CpuAddr,
    input  logic [W-1:0] CpuWrData,
    output logic [W-1:0] CpuRdData,
    output logic         MemWrite,
    output logic [A-1:0] MemAddr,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData
);

    localparam logic [A-1:0] AddrOne = A'(1);
    localparam logic [A:0]   RemOne  = (A+1)'(1);

    state_e       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A:0]   rem_q, rem_d;
    logic [W-1:0] hold_q, hold_d;
`ifdef MEM_COPY_FILL_EN
    logic         fill_q, fill_d;
    logic [W-1:0] fill_val_q, fill_val_d;
`endif

    // Loads are never intercepted; the core always sees the memory's read port.
    assign CpuRdData = MemRdData;

    // Next-state, counter updates and memory-pin mux.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        hold_d    = hold_q;
`ifdef MEM_COPY_FILL_EN
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
`endif
        Busy      = 1'b0;
        Done      = 1'b0;
        MemWrite  = CpuMemWrite;
        MemAddr   = CpuAddr;
        MemWrData = CpuWrData;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (Length == '0) begin
                        state_d = StDone;
                    end else begin
                        src_d   = SrcAddr;
                        dst_d   = DstAddr;
                        rem_d   = Length;
                        state_d = StRead;
`ifdef MEM_COPY_FILL_EN
                        fill_d     = Fill;
                        fill_val_d = FillValue;
                        if (Fill) state_d = StWrite;
`endif
                    end
                end
            end
            StRead: begin
                Busy      = 1'b1;
                MemWrite  = 1'b0;
                MemAddr   = src_q;
                MemWrData = hold_q;
                hold_d    = MemRdData;
                state_d   = StWrite;
            end
            StWrite: begin
                Busy      = 1'b1;
                MemWrite  = 1'b1;
                MemAddr   = dst_q;
                MemWrData = hold_q;
                src_d     = src_q + AddrOne;
                dst_d     = dst_q + AddrOne;
                rem_d     = rem_q - RemOne;
                state_d   = (rem_q == RemOne) ? StDone : StRead;
`ifdef MEM_COPY_FILL_EN
                if (fill_q) begin
                    MemWrData = fill_val_q;
                    if (rem_q != RemOne) state_d = StWrite;
                end
`endif
            end
            StDone: begin
                Done    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any copy in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
`ifdef MEM_COPY_FILL_EN
            fill_q     <= 1'b0;
            fill_val_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
`ifdef MEM_COPY_FILL_EN
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: stimulus pushes expected memory writes and
// Done events; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_copy_engine;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        int cyc;
        int busy;
    } done_t;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [8:0] Length;
`ifdef MEM_COPY_FILL_EN
    logic       Fill;
    logic [7:0] FillValue;
`endif
    logic       Busy;
    logic       Done;
    logic       CpuMemWrite;
    logic [7:0] CpuAddr;
    logic [7:0] CpuWrData;
    logic [7:0] CpuRdData;
    logic       MemWrite;
    logic [7:0] MemAddr;
    logic [7:0] MemWrData;
    logic [7:0] MemRdData;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       mem_clear;

    wr_t   wq[$];
    done_t dq[$];
    int    cyc = 0;
    int    busy_cnt = 0;
    int    checks = 0;
    int    failures = 0;

    mem_copy_engine dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
`ifdef MEM_COPY_FILL_EN
        .Fill       (Fill),
        .FillValue  (FillValue),
`endif
        .Busy       (Busy),
        .Done       (Done),
        .CpuMemWrite(CpuMemWrite),
        .CpuAddr    (CpuAddr),
        .CpuWrData  (CpuWrData),
        .CpuRdData  (CpuRdData),
        .MemWrite   (MemWrite),
        .MemAddr    (MemAddr),
        .MemWrData  (MemWrData),
        .MemRdData  (MemRdData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Single-port memory: combinational read, write on rising edge.
    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (MemWrite) begin
            mem[MemAddr] <= MemWrData;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every memory write and Done pulse against the scoreboard.
    always @(negedge Clk) begin
        if (Reset) begin
            busy_cnt = 0;
        end else begin
            check("cpu_rd_data", {24'd0, CpuRdData}, {24'd0, mem[MemAddr]});
            if (Busy) busy_cnt++;
            if (MemWrite) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                             MemAddr, MemWrData);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("write_addr", {24'd0, MemAddr}, {24'd0, e.addr});
                    check("write_data", {24'd0, MemWrData}, {24'd0, e.data});
                end
            end
            if (Done) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d expected none", cyc);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("busy_cycles", busy_cnt, d.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cpu_store(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
        ref_mem[a] = d;
        CpuMemWrite = 1'b1;
        CpuAddr = a;
        CpuWrData = d;
        step();
        CpuMemWrite = 1'b0;
    endtask

    // Reference: forward word-by-word copy (or fill) with 8-bit address wrap.
    task automatic model_words(input logic [7:0] s, input logic [7:0] d, input int n,
                               input bit fill, input logic [7:0] fv);
        for (int i = 0; i < n; i++) begin
            logic [7:0] as;
            logic [7:0] ad;
            wr_t e;
            as = s + 8'(i);
            ad = d + 8'(i);
            e.addr = ad;
            e.data = fill ? fv : ref_mem[as];
            ref_mem[ad] = e.data;
            wq.push_back(e);
        end
    endtask

    task automatic issue(input logic [7:0] s, input logic [7:0] d, input int n,
                         input bit fill, input logic [7:0] fv);
        done_t dn;
        model_words(s, d, n, fill, fv);
        dn.busy = fill ? n : 2 * n;
        dn.cyc  = cyc + dn.busy + 1;
        dq.push_back(dn);
        Start = 1'b1;
        SrcAddr = s;
        DstAddr = d;
        Length = 9'(n);
`ifdef MEM_COPY_FILL_EN
        Fill = fill;
        FillValue = fv;
`endif
        step();
        Start = 1'b0;
`ifdef MEM_COPY_FILL_EN
        Fill = 1'b0;
`endif
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((dq.size() != 0 || wq.size() != 0) && k < bound) begin
            step();
            k++;
        end
        check("completion_timeout", {31'd0, (dq.size() != 0 || wq.size() != 0)}, 32'd0);
        dq.delete();
        wq.delete();
    endtask

    initial begin
        logic [7:0] pre [4];
        int         mism;
        pre[0] = 8'hAA;
        pre[1] = 8'hBB;
        pre[2] = 8'hCC;
        pre[3] = 8'hDD;
        Reset = 1'b1;
        Start = 1'b0;
        SrcAddr = '0;
        DstAddr = '0;
        Length = '0;
`ifdef MEM_COPY_FILL_EN
        Fill = 1'b0;
        FillValue = '0;
`endif
        CpuMemWrite = 1'b0;
        CpuAddr = 8'h3C;
        CpuWrData = '0;
        mem_clear = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        step();
        step();
        mem_clear = 1'b0;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_addr_pass", {24'd0, MemAddr}, 32'h3C);
        Reset = 1'b0;
        step();

        // Preload and directed 4-word copy.
        for (int i = 0; i < 4; i++) cpu_store(8'h10 + 8'(i), pre[i]);
        issue(8'h10, 8'h80, 4, 1'b0, 8'h00);
        wait_idle(100);
        for (int i = 0; i < 4; i++) check("copy_0x80", {24'd0, mem[8'h80 + 8'(i)]}, {24'd0, pre[i]});

        // Zero length: Done next cycle, no Busy, no writes.
        issue(8'h10, 8'hC0, 0, 1'b0, 8'h00);
        wait_idle(20);

        // Source wraps past 0xFF.
        cpu_store(8'hFE, 8'h11);
        cpu_store(8'hFF, 8'h22);
        cpu_store(8'h00, 8'h33);
        cpu_store(8'h01, 8'h44);
        issue(8'hFE, 8'h40, 4, 1'b0, 8'h00);
        wait_idle(100);
        check("wrap_0x42", {24'd0, mem[8'h42]}, 32'h33);

        // Idle store lands; same store while busy is suppressed.
        cpu_store(8'h22, 8'h5A);
        issue(8'h50, 8'h60, 6, 1'b0, 8'h00);
        CpuMemWrite = 1'b1;
        CpuAddr = 8'h22;
        CpuWrData = 8'hEE;
        for (int i = 0; i < 4; i++) step();
        CpuMemWrite = 1'b0;
        wait_idle(100);
        check("store_while_busy", {24'd0, mem[8'h22]}, 32'h5A);

        // Second Start mid-copy is ignored.
        issue(8'h10, 8'h90, 4, 1'b0, 8'h00);
        step();
        Start = 1'b1;
        SrcAddr = 8'h00;
        DstAddr = 8'hB0;
        Length = 9'd3;
        step();
        Start = 1'b0;
        wait_idle(100);

        // Reset after the 2nd WRITE of a 4-word copy.
        model_words(8'h10, 8'hA0, 2, 1'b0, 8'h00);
        Start = 1'b1;
        SrcAddr = 8'h10;
        DstAddr = 8'hA0;
        Length = 9'd4;
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("abort_pending_writes", wq.size(), 32'd0);
        wq.delete();

        // Overlapping forward copy and a whole-memory copy.
        issue(8'h10, 8'h12, 6, 1'b0, 8'h00);
        wait_idle(100);
        issue(8'h00, 8'h80, 256, 1'b0, 8'h00);
        wait_idle(600);

`ifdef MEM_COPY_FILL_EN
        issue(8'h00, 8'hF8, 12, 1'b1, 8'hC3);
        wait_idle(100);
`endif

        // Randomized stores and copies.
        for (int it = 0; it < 20; it++) begin
            int ns;
            ns = $urandom_range(0, 3);
            for (int j = 0; j < ns; j++) cpu_store(8'($urandom), 8'($urandom));
            issue(8'($urandom), 8'($urandom), $urandom_range(0, 20), 1'b0, 8'h00);
            wait_idle(100);
        end

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("final_memory_mismatches", mism, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
